// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter between two byte requesters.
// The winning byte is latched on grant and shifted out LSB first on TX_OUT.
//
// state | meaning
// IDLE  | line high, waiting for REQ0/REQ1; grants on the first edge a request is seen
// START | start bit (TX_OUT=0) for CLKS_PER_BIT cycles
// DATA  | DATA_W data bits, LSB first, one per CLKS_PER_BIT cycles
// STOP  | stop bit (TX_OUT=1); DONE is high in its final cycle
module usart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 12,
  parameter int DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DATA0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              ACK0,
  output logic              ACK1,
  output logic              GNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              TX_OUT
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_q, tx_d;
  logic              pick1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    // ptr_q=1 means requester 1 wins a tie
    pick1   = REQ1 & (~REQ0 | ptr_q);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (REQ0 | REQ1) begin
          gnt_d   = pick1;
          ptr_d   = ~pick1;
          sh_d    = pick1 ? DATA1 : DATA0;
          ack0_d  = ~pick1;
          ack1_d  = pick1;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_d[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          // registered, so raise it one edge early to land on the final cycle
          done_d = (cnt_q == CNT_PRE_LAST);
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  assign ACK0   = ack0_q;
  assign ACK1   = ack1_q;
  assign GNT    = gnt_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign TX_OUT = tx_q;

endmodule
